// File: rtl/tcam_lookup_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tcam_lookup_ctrl
// Brief    : Arbitrates flush/write/lookup commands onto a TCAM wrapper and
//            returns ordered lookup results with saturating hit/miss counters.
// Revision : 1.0 - initial release
// =============================================================================
module tcam_lookup_ctrl #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_LAT    = 3,
  parameter int RSP_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [2*ID_WIDTH-1:0] wr_data,
  input  logic [2*ID_WIDTH-1:0] wr_mskb,
  input  logic                  wr_vbi,
  input  logic                  flush_req,
  output logic                  flush_ack,
  output logic [2:0]            mem_mode,
  output logic [ID_WIDTH-1:0]   mem_pkt_id,
  output logic [2*ID_WIDTH-1:0] mem_data,
  output logic [2*ID_WIDTH-1:0] mem_mskb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_vbe,
  output logic                  mem_dcs,
  output logic                  mem_vbi,
  input  logic [ID_WIDTH-1:0]   mem_dst_id,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_WIDTH-1:0]   rsp_dst_id,
  output logic                  rsp_hit,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int C_PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int C_FCNT_W = $clog2(RSP_DEPTH + 1);
  localparam int C_OCC_W  = $clog2(RSP_DEPTH + RSP_LAT + 1);

  localparam logic [C_PTR_W-1:0] C_PTR_LAST   = C_PTR_W'(RSP_DEPTH - 1);
  localparam logic [2:0]         C_MODE_IDLE  = 3'b000;
  localparam logic [2:0]         C_MODE_WRITE = 3'b001;
  localparam logic [2:0]         C_MODE_FLUSH = 3'b011;
  localparam logic [2:0]         C_MODE_CMP   = 3'b100;

  typedef enum logic [0:0] {
    ST_ISSUE    = 1'b0,
    ST_CMP_HOLD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   pkt_id_q, pkt_id_d;
  logic [RSP_LAT-1:0]    pipe_q, pipe_d;
  logic [ID_WIDTH-1:0]   fifo_mem_q [RSP_DEPTH];
  logic [C_PTR_W-1:0]    wptr_q, rptr_q;
  logic [C_FCNT_W-1:0]   count_q;
  logic [CNT_WIDTH-1:0]  hit_q, miss_q;

  logic                  w_issue_cmp;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit;
  logic [C_OCC_W-1:0]    w_occ;

  function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid  = (count_q != '0);
  assign rsp_dst_id = rsp_valid ? fifo_mem_q[rptr_q] : '0;
  assign rsp_hit    = rsp_valid && (rsp_dst_id != '0);
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

  assign w_pop  = rsp_valid && rsp_ready;
  assign w_push = pipe_q[RSP_LAT-1];

  // A slot is owned from issue until the response leaves the FIFO; a pop this
  // cycle hands its slot straight to a new lookup.
  always_comb begin
    w_occ = C_OCC_W'(count_q);
    for (int i = 0; i < RSP_LAT; i++) begin
      w_occ = w_occ + C_OCC_W'(pipe_q[i]);
    end
  end

  assign w_credit = w_occ < (C_OCC_W'(RSP_DEPTH) + C_OCC_W'(w_pop));

  always_comb begin
    pipe_d[0] = w_issue_cmp;
    for (int i = 1; i < RSP_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    pkt_id_d    = pkt_id_q;
    w_issue_cmp = 1'b0;
    mem_mode    = C_MODE_IDLE;
    mem_pkt_id  = '0;
    mem_data    = '0;
    mem_mskb    = '0;
    mem_addr    = '0;
    mem_vbe     = 1'b0;
    mem_dcs     = 1'b0;
    mem_vbi     = 1'b0;
    flush_ack   = 1'b0;
    wr_ready    = 1'b0;
    req_ready   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_ISSUE: begin
          wr_ready  = !flush_req;
          req_ready = !flush_req && !wr_valid && w_credit;
          if (flush_req) begin
            mem_mode  = C_MODE_FLUSH;
            flush_ack = 1'b1;
          end else if (wr_valid) begin
            mem_mode = C_MODE_WRITE;
            mem_data = wr_data;
            mem_mskb = wr_mskb;
            mem_addr = wr_addr;
            mem_vbi  = wr_vbi;
            mem_vbe  = 1'b1;
            mem_dcs  = 1'b1;
          end else if (req_valid && w_credit) begin
            mem_mode    = C_MODE_CMP;
            mem_pkt_id  = req_id;
            pkt_id_d    = req_id;
            w_issue_cmp = 1'b1;
            state_d     = ST_CMP_HOLD;
          end
        end
        ST_CMP_HOLD: begin
          // The TCAM is mid-compare and ignores MODE; keep its key stable.
          mem_pkt_id = pkt_id_q;
          state_d    = ST_ISSUE;
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ISSUE;
      pkt_id_q <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      pkt_id_q <= pkt_id_d;
      pipe_q   <= pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wptr_q] <= mem_dst_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      if (w_push) begin
        wptr_q <= ptr_inc(wptr_q);
        if (mem_dst_id != '0) begin
          if (hit_q != '1) hit_q <= hit_q + 1'b1;
        end else begin
          if (miss_q != '1) miss_q <= miss_q + 1'b1;
        end
      end
      if (w_pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      unique case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && (count_q == C_FCNT_W'(RSP_DEPTH))))
        else $error("tcam_lookup_ctrl: response FIFO overflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcam_lookup_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_tcam_lookup_ctrl
// Brief    : Directed + randomized bench with a behavioural TCAM and table model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_tcam_lookup_ctrl;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 4;
  localparam int RSP_LAT    = 3;
  localparam int RSP_DEPTH  = 2;
  // Narrow counters so saturation is reached during the random phase.
  localparam int CNT_WIDTH  = 4;
  localparam int W          = 2 * ID_WIDTH;
  localparam int NENT       = 1 << ADDR_WIDTH;
  localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid, req_ready, wr_valid, wr_ready, wr_vbi;
  logic [ID_WIDTH-1:0]   req_id;
  logic [ADDR_WIDTH-1:0] wr_addr, mem_addr;
  logic [W-1:0]          wr_data, wr_mskb, mem_data, mem_mskb;
  logic                  flush_req, flush_ack;
  logic [2:0]            mem_mode;
  logic [ID_WIDTH-1:0]   mem_pkt_id, mem_dst_id, rsp_dst_id;
  logic                  mem_vbe, mem_dcs, mem_vbi;
  logic                  rsp_valid, rsp_ready, rsp_hit;
  logic [CNT_WIDTH-1:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  tcam_lookup_ctrl #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RSP_LAT(RSP_LAT),
    .RSP_DEPTH(RSP_DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mskb(wr_mskb), .wr_vbi(wr_vbi),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .mem_mode(mem_mode), .mem_pkt_id(mem_pkt_id), .mem_data(mem_data),
    .mem_mskb(mem_mskb), .mem_addr(mem_addr), .mem_vbe(mem_vbe),
    .mem_dcs(mem_dcs), .mem_vbi(mem_vbi), .mem_dst_id(mem_dst_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dst_id(rsp_dst_id),
    .rsp_hit(rsp_hit), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // TCAM device model (driven by mem_*) and reference table (driven by handshakes).
  logic [W-1:0]        tc_data [NENT];
  logic [W-1:0]        tc_mskb [NENT];
  logic                tc_vld  [NENT];
  logic [W-1:0]        rf_data [NENT];
  logic [W-1:0]        rf_mskb [NENT];
  logic                rf_vld  [NENT];
  logic [ID_WIDTH-1:0] sched   [16];
  logic                sched_v [16];
  logic [3:0]          slot = 4'd0;
  logic [ID_WIDTH-1:0] exp_q [$];
  logic [ID_WIDTH-1:0] m_e;
  int                  exp_hit = 0, exp_miss = 0, rsp_seen = 0;

  function automatic logic [ID_WIDTH-1:0] match(input logic use_ref, input logic [ID_WIDTH-1:0] key);
    for (int a = 0; a < NENT; a++) begin
      if (use_ref ? rf_vld[a] : tc_vld[a]) begin
        logic [W-1:0] d, m;
        d = use_ref ? rf_data[a] : tc_data[a];
        m = use_ref ? rf_mskb[a] : tc_mskb[a];
        if (((key ^ d[W-1:ID_WIDTH]) & m[W-1:ID_WIDTH]) == '0) return d[ID_WIDTH-1:0];
      end
    end
    return '0;
  endfunction

  always @(negedge clk) begin
    slot = slot + 4'd1;
    if (sched_v[slot]) begin
      mem_dst_id    = sched[slot];
      sched_v[slot] = 1'b0;
    end else begin
      mem_dst_id = ID_WIDTH'($urandom_range(1, (1 << ID_WIDTH) - 1));
    end
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          chk("rsp_extra", {31'd0, rsp_valid}, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_dst", {28'd0, rsp_dst_id}, {28'd0, m_e});
          chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, (m_e != '0)});
        end
      end
      case (mem_mode)
        3'b001: if (mem_vbe) begin
          tc_data[mem_addr] = mem_data;
          tc_mskb[mem_addr] = mem_mskb;
          tc_vld[mem_addr]  = mem_vbi;
        end
        3'b011: for (int a = 0; a < NENT; a++) tc_vld[a] = 1'b0;
        3'b100: begin
          sched[slot + 4'(RSP_LAT)]   = match(1'b0, mem_pkt_id);
          sched_v[slot + 4'(RSP_LAT)] = 1'b1;
        end
        default: ;
      endcase
      if (flush_req && flush_ack) for (int a = 0; a < NENT; a++) rf_vld[a] = 1'b0;
      if (wr_valid && wr_ready) begin
        rf_data[wr_addr] = wr_data;
        rf_mskb[wr_addr] = wr_mskb;
        rf_vld[wr_addr]  = wr_vbi;
      end
      if (req_valid && req_ready) begin
        m_e = match(1'b1, req_id);
        exp_q.push_back(m_e);
        if (m_e != '0) begin
          if (exp_hit < CNT_MAX) exp_hit++;
        end else begin
          if (exp_miss < CNT_MAX) exp_miss++;
        end
      end
    end
  end

  // Caller is just after a rising edge; returns on the negedge of the response cycle.
  task automatic lookup1(input logic [ID_WIDTH-1:0] id, output logic [ID_WIDTH-1:0] dst,
                         output logic hit, output int lat);
    int budget;
    req_valid = 1'b1;
    req_id    = id;
    budget    = 0;
    @(negedge clk);
    while (!req_ready && budget < 20) begin @(negedge clk); budget++; end
    chk("lookup_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_mode", {29'd0, mem_mode}, 32'd0);
    chk("hold_pkt", {28'd0, mem_pkt_id}, {28'd0, id});
    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    dst = rsp_dst_id;
    hit = rsp_hit;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ID_WIDTH-1:0] dst;
    logic                hit, last_rdy, seen;
    logic [19:0]         pat;
    int                  lat, acc, base;

    for (int a = 0; a < NENT; a++) begin tc_vld[a] = 1'b0; rf_vld[a] = 1'b0; end
    for (int s = 0; s < 16; s++) sched_v[s] = 1'b0;
    req_valid = 0; req_id = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    wr_mskb = '0; wr_vbi = 0; flush_req = 0; rsp_ready = 1; mem_dst_id = '0;
    req_valid = 1; wr_valid = 1; flush_req = 1;

    // Reset state, with requests pending to prove outputs are held low.
    @(negedge clk);
    chk("rst_mode", {29'd0, mem_mode}, 32'd0);
    chk("rst_readies", {29'd0, req_ready, wr_ready, flush_ack}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cnts", {24'd0, hit_cnt, miss_cnt}, 32'd0);
    @(posedge clk); #1;
    req_valid = 0; wr_valid = 0; flush_req = 0;
    rst = 0;

    // T1: write then immediate lookup.
    wr_valid = 1; wr_addr = 4'd3; wr_data = 8'h5A; wr_mskb = 8'hF0; wr_vbi = 1;
    @(negedge clk);
    chk("t1_wr_mode", {29'd0, mem_mode}, 32'd1);
    chk("t1_wr_fields", {11'd0, mem_addr, mem_data, mem_mskb, mem_vbe, mem_dcs, mem_vbi},
        {11'd0, 4'd3, 8'h5A, 8'hF0, 3'b111});
    chk("t1_wr_ready", {31'd0, wr_ready}, 32'd1);
    @(posedge clk); #1;
    wr_valid = 0;
    lookup1(4'd5, dst, hit, lat);
    chk("t1_latency", lat, RSP_LAT + 1);
    chk("t1_dst", {28'd0, dst}, 32'hA);
    chk("t1_hit", {31'd0, hit}, 32'd1);
    chk("t1_hit_cnt", {28'd0, hit_cnt}, 32'd1);

    // T2: miss.
    @(posedge clk); #1;
    lookup1(4'd7, dst, hit, lat);
    chk("t2_dst", {28'd0, dst}, 32'd0);
    chk("t2_hit", {31'd0, hit}, 32'd0);
    @(negedge clk);
    chk("t2_miss_cnt", {28'd0, miss_cnt}, 32'd1);

    // T3: back-to-back requests, one accept every second cycle.
    @(posedge clk); #1;
    base = rsp_seen;
    pat  = '0;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1; req_id = ID_WIDTH'($urandom);
      @(negedge clk);
      pat[i] = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
    repeat (10) @(negedge clk);
    chk("t3_ready_pattern", {12'd0, pat}, 32'h55555);
    chk("t3_rsp_count", rsp_seen - base, 10);
    chk("t3_drained", exp_q.size(), 0);

    // T4: stalled responses limit accepts to the FIFO depth.
    @(posedge clk); #1;
    rsp_ready = 0; acc = 0; last_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1; req_id = ID_WIDTH'($urandom);
      @(negedge clk);
      if (req_ready) acc++;
      last_rdy = req_ready;
      @(posedge clk); #1;
    end
    chk("t4_accepts", acc, RSP_DEPTH);
    chk("t4_ready_low", {31'd0, last_rdy}, 32'd0);
    chk("t4_rsp_stalled", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      req_id = ID_WIDTH'($urandom);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("t4_resume", acc, 6);
    repeat (10) @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);

    // T5: flush beats write beats lookup.
    @(posedge clk); #1;
    flush_req = 1; wr_valid = 1; wr_addr = 4'd6; wr_data = 8'h9C; wr_mskb = 8'hF0; wr_vbi = 1;
    req_valid = 1; req_id = 4'd5;
    @(negedge clk);
    chk("t5_flush", {28'd0, mem_mode, flush_ack}, {28'd0, 3'b011, 1'b1});
    chk("t5_flush_readies", {30'd0, wr_ready, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush_req = 0;
    @(negedge clk);
    chk("t5_write", {27'd0, mem_mode, wr_ready, flush_ack}, {27'd0, 3'b001, 1'b1, 1'b0});
    chk("t5_write_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    wr_valid = 0;
    @(negedge clk);
    chk("t5_lookup", {28'd0, mem_mode, req_ready}, {28'd0, 3'b100, 1'b1});
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    chk("t5_flushed_dst", {27'd0, rsp_hit, rsp_dst_id}, 32'd0);
    @(posedge clk); #1;
    lookup1(4'd9, dst, hit, lat);
    chk("t5_new_entry", {27'd0, hit, dst}, {27'd0, 1'b1, 4'hC});
    @(negedge clk);
    chk("t5_hit_cnt", {28'd0, hit_cnt}, exp_hit);
    chk("t5_miss_cnt", {28'd0, miss_cnt}, exp_miss);

    // Random mix of flushes, writes, lookups and response back-pressure.
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      flush_req = ($urandom_range(0, 39) == 0);
      wr_valid  = ($urandom_range(0, 5) == 0);
      wr_addr   = ADDR_WIDTH'($urandom);
      wr_data   = W'($urandom);
      wr_mskb   = W'($urandom);
      wr_vbi    = ($urandom_range(0, 3) != 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_id    = ID_WIDTH'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    flush_req = 0; wr_valid = 0; req_valid = 0; rsp_ready = 1;
    repeat (12) @(negedge clk);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_hit_cnt", {28'd0, hit_cnt}, exp_hit);
    chk("rand_miss_cnt", {28'd0, miss_cnt}, exp_miss);

    // T6: reset during CMP_HOLD drops the in-flight lookup.
    @(posedge clk); #1;
    req_valid = 1; req_id = 4'd9;
    @(negedge clk);
    chk("t6_issue", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    #1;
    chk("t6_mode", {29'd0, mem_mode}, 32'd0);
    chk("t6_cnts", {24'd0, hit_cnt, miss_cnt}, 32'd0);
    chk("t6_rsp", {31'd0, rsp_valid}, 32'd0);
    exp_q.delete();
    exp_hit = 0; exp_miss = 0;
    @(posedge clk); #1;
    rst = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("t6_no_rsp", {31'd0, seen}, 32'd0);

    // Post-reset: lowest address wins, visible to a lookup issued the next cycle.
    @(posedge clk); #1;
    wr_valid = 1; wr_addr = 4'd0; wr_data = 8'h3E; wr_mskb = 8'hF0; wr_vbi = 1;
    @(posedge clk); #1;
    wr_valid = 0;
    lookup1(4'd3, dst, hit, lat);
    chk("post_rst_lookup", {27'd0, hit, dst}, {27'd0, 1'b1, 4'hE});
    @(negedge clk);
    chk("post_rst_hit_cnt", {28'd0, hit_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
